// File: rtl/sd_sector_responder.sv
// Target side of the core's sector-block handshake: services one 512-byte sector
// per request against a byte-wide req/ack memory port (read: mem -> core buffer, write: core buffer -> mem).
module sd_sector_responder #(
   parameter int ADDR_W   = 24,
   parameter int BUFF_LAT = 1,
   parameter int ACK_GAP  = 2
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [31:0]       sd_lba,
   input  logic              sd_rd,
   input  logic              sd_wr,
   output logic              sd_ack,
   output logic [8:0]        sd_buff_addr,
   output logic [7:0]        sd_buff_dout,
   output logic              sd_buff_wr,
   input  logic [7:0]        sd_buff_din,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              busy
);

   localparam int SEC_W = ADDR_W - 9;
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_PUT, WR_SETTLE, WR_REQ, DONE, GAP} state_t;

   state_t             state_q, state_d;
   logic [SEC_W-1:0]   lba_q, lba_d;
   logic [8:0]         idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sd_ack_q, sd_ack_d;
   logic [8:0]         sd_buff_addr_q, sd_buff_addr_d;
   logic [7:0]         sd_buff_dout_q, sd_buff_dout_d;
   logic               sd_buff_wr_q, sd_buff_wr_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic [7:0]         mem_wdata_q, mem_wdata_d;
   logic               busy_q, busy_d;

   // Only the low LBA bits select a sector inside the backing region.
   logic unused_lba;
   assign unused_lba = ^sd_lba[31:SEC_W];

   always_comb begin
      state_d        = state_q;
      lba_d          = lba_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      sd_ack_d       = sd_ack_q;
      sd_buff_addr_d = sd_buff_addr_q;
      sd_buff_dout_d = sd_buff_dout_q;
      sd_buff_wr_d   = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_wdata_d    = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (sd_rd || sd_wr) begin
               lba_d          = sd_lba[SEC_W-1:0];
               idx_d          = 9'd0;
               cnt_d          = '0;
               sd_ack_d       = 1'b1;
               sd_buff_addr_d = 9'd0;
               if (sd_rd) begin
                  state_d    = RD_REQ;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {sd_lba[SEC_W-1:0], 9'd0};
               end else begin
                  state_d = WR_SETTLE;
               end
            end
         end
         RD_REQ: begin
            if (mem_ack) begin
               mem_req_d      = 1'b0;
               sd_buff_dout_d = mem_rdata;
               sd_buff_addr_d = idx_q;
               sd_buff_wr_d   = 1'b1;
               state_d        = RD_PUT;
            end
         end
         RD_PUT: begin
            if (idx_q == 9'd511) begin
               state_d  = DONE;
               sd_ack_d = 1'b0;
            end else begin
               idx_d      = idx_q + 9'd1;
               mem_req_d  = 1'b1;
               mem_addr_d = {lba_q, idx_q + 9'd1};
               state_d    = RD_REQ;
            end
         end
         WR_SETTLE: begin
            // sd_buff_addr has been stable since entry; din is valid BUFF_LAT cycles later.
            if (cnt_q == CNT_W'(BUFF_LAT)) begin
               mem_wdata_d = sd_buff_din;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {lba_q, idx_q};
               state_d     = WR_REQ;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_REQ: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (idx_q == 9'd511) begin
                  state_d  = DONE;
                  sd_ack_d = 1'b0;
               end else begin
                  idx_d          = idx_q + 9'd1;
                  sd_buff_addr_d = idx_q + 9'd1;
                  cnt_d          = '0;
                  state_d        = WR_SETTLE;
               end
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = (ACK_GAP == 0) ? IDLE : GAP;
         end
         GAP: begin
            if (cnt_q == CNT_W'(ACK_GAP - 1)) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q        <= IDLE;
         lba_q          <= '0;
         idx_q          <= '0;
         cnt_q          <= '0;
         sd_ack_q       <= 1'b0;
         sd_buff_addr_q <= '0;
         sd_buff_dout_q <= '0;
         sd_buff_wr_q   <= 1'b0;
         mem_addr_q     <= '0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_wdata_q    <= '0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         lba_q          <= lba_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         sd_ack_q       <= sd_ack_d;
         sd_buff_addr_q <= sd_buff_addr_d;
         sd_buff_dout_q <= sd_buff_dout_d;
         sd_buff_wr_q   <= sd_buff_wr_d;
         mem_addr_q     <= mem_addr_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_wdata_q    <= mem_wdata_d;
         busy_q         <= busy_d;
      end
   end

   assign sd_ack       = sd_ack_q;
   assign sd_buff_addr = sd_buff_addr_q;
   assign sd_buff_dout = sd_buff_dout_q;
   assign sd_buff_wr   = sd_buff_wr_q;
   assign mem_addr     = mem_addr_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_wdata    = mem_wdata_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Scoreboard bench for sd_sector_responder: directed sectors push expected
// buffer strobes / memory writes; a monitor pops and compares as the DUT emits them.
module tb_sd_sector_responder;

   localparam int ADDR_W = 24;

   logic              clk_sys = 1'b0;
   logic              reset   = 1'b1;
   logic [31:0]       sd_lba  = '0;
   logic              sd_rd   = 1'b0;
   logic              sd_wr   = 1'b0;
   logic              sd_ack;
   logic [8:0]        sd_buff_addr;
   logic [7:0]        sd_buff_dout;
   logic              sd_buff_wr;
   logic [7:0]        sd_buff_din = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_req;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata = '0;
   logic              mem_ack   = 1'b0;
   logic              busy;

   always #5 clk_sys = ~clk_sys;

   sd_sector_responder #(.ADDR_W(ADDR_W), .BUFF_LAT(1), .ACK_GAP(2)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
      .sd_buff_din(sd_buff_din),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Backing memory and core buffer (registered BRAM, one cycle read latency)
   logic [7:0] mem [int];
   logic [7:0] core_buf [512];
   always @(posedge clk_sys) sd_buff_din <= core_buf[sd_buff_addr];

   logic [31:0] rd_q[$];
   logic [31:0] wr_q[$];
   int n_strobe = 0, n_mwr = 0, n_mrd = 0, n_ack_rise = 0, n_issued = 0;

   // Memory port model with random stalls and request stability tracking
   int                stall_max = 0;
   bit                late_ack  = 1'b0;
   bit                m_active  = 1'b0;
   bit                m_stable  = 1'b1;
   int                m_stall   = 0;
   logic [ADDR_W-1:0] m_addr;
   logic              m_we;
   logic [7:0]        m_wdata;

   initial begin
      forever begin
         @(posedge clk_sys); #2;
         if (reset) begin
            m_active = 1'b0;
            mem_ack  = 1'b0;
         end else if (mem_ack) begin
            mem_ack  = 1'b0;
            m_active = 1'b0;
         end else if (late_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hEE;
            late_ack  = 1'b0;
         end else if (mem_req) begin
            if (!m_active) begin
               m_active = 1'b1;
               m_addr   = mem_addr;
               m_we     = mem_we;
               m_wdata  = mem_wdata;
               m_stable = 1'b1;
               m_stall  = $urandom_range(stall_max, 0);
            end else if (mem_addr !== m_addr || mem_we !== m_we || mem_wdata !== m_wdata) begin
               m_stable = 1'b0;
            end
            if (m_stall == 0) begin
               check("mem_req_stable", 64'(m_stable), 64'd1);
               if (m_we) mem[int'(m_addr)] = m_wdata;
               else mem_rdata = mem.exists(int'(m_addr)) ? mem[int'(m_addr)] : 8'h00;
               mem_ack = 1'b1;
            end else begin
               m_stall--;
            end
         end
      end
   end

   // Monitor: compares every emitted strobe / memory write against the scoreboard
   logic ack_prev = 1'b0;
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk_sys);
         if (sd_ack && !ack_prev) n_ack_rise++;
         ack_prev = sd_ack;
         if (sd_buff_wr) begin
            n_strobe++;
            check("buff_wr_expected", 64'(rd_q.size() != 0), 64'd1);
            check("ack_during_read", 64'(sd_ack), 64'd1);
            if (rd_q.size() != 0) begin
               e = rd_q.pop_front();
               check("buff_wr_addr_data", 64'({sd_buff_addr, sd_buff_dout}), 64'(e));
            end
         end
         if (mem_req && mem_ack) begin
            if (mem_we) begin
               n_mwr++;
               check("mem_wr_expected", 64'(wr_q.size() != 0), 64'd1);
               check("ack_during_write", 64'(sd_ack), 64'd1);
               if (wr_q.size() != 0) begin
                  e = wr_q.pop_front();
                  check("mem_wr_addr_data", 64'({mem_addr, mem_wdata}), 64'(e));
               end
            end else begin
               n_mrd++;
            end
         end
      end
   end

   task automatic sector(input bit rd, input bit wr, input logic [31:0] lba);
      int t;
      @(posedge clk_sys); #1;
      sd_lba = lba; sd_rd = rd; sd_wr = wr;
      n_issued++;
      t = 0;
      while (!sd_ack && t < 100) begin @(posedge clk_sys); #1; t++; end
      check("ack_rise_in_time", 64'(t < 100), 64'd1);
      sd_rd = 1'b0; sd_wr = 1'b0;
      t = 0;
      while (sd_ack && t < 20000) begin @(posedge clk_sys); #1; t++; end
      check("ack_fall_in_time", 64'(t < 20000), 64'd1);
      t = 0;
      while (busy && t < 20) begin @(posedge clk_sys); #1; t++; end
      check("idle_after_gap", 64'(t < 20), 64'd1);
   endtask

   task automatic check_counts(input string name, input int s0, input int w0,
                               input int exp_strobe, input int exp_mwr);
      check({name, "_strobes"}, 64'(n_strobe - s0), 64'(exp_strobe));
      check({name, "_memwrites"}, 64'(n_mwr - w0), 64'(exp_mwr));
      check({name, "_rdq_empty"}, 64'(rd_q.size()), 64'd0);
      check({name, "_wrq_empty"}, 64'(wr_q.size()), 64'd0);
   endtask

   initial begin
      int s0, w0, t, s_at_rst;
      for (int i = 0; i < 512; i++) core_buf[i] = 8'h00;

      // Reset state
      repeat (3) @(posedge clk_sys);
      #1;
      check("rst_sd_ack", 64'(sd_ack), 64'd0);
      check("rst_buff_wr", 64'(sd_buff_wr), 64'd0);
      check("rst_buff_addr", 64'(sd_buff_addr), 64'd0);
      check("rst_buff_dout", 64'(sd_buff_dout), 64'd0);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;

      // Read lba=5: region 0xA00, data i^0x5A
      for (int i = 0; i < 512; i++) begin
         mem[32'hA00 + i] = 8'(i) ^ 8'h5A;
         rd_q.push_back(32'({9'(i), 8'(i) ^ 8'h5A}));
      end
      s0 = n_strobe; w0 = n_mwr;
      sector(1'b1, 1'b0, 32'd5);
      check_counts("read5", s0, w0, 512, 0);

      // Upper LBA bits ignored: 0x18005 maps to sector 5 again
      for (int i = 0; i < 512; i++) rd_q.push_back(32'({9'(i), 8'(i) ^ 8'h5A}));
      s0 = n_strobe; w0 = n_mwr;
      sector(1'b1, 1'b0, 32'h0001_8005);
      check_counts("read_hi_lba", s0, w0, 512, 0);

      // Write lba=3: 0x600..0x7FF with ~i
      for (int i = 0; i < 512; i++) begin
         core_buf[i] = ~8'(i);
         wr_q.push_back(32'({24'(32'h600 + i), ~8'(i)}));
      end
      s0 = n_strobe; w0 = n_mwr;
      sector(1'b0, 1'b1, 32'd3);
      check_counts("write3", s0, w0, 0, 512);
      check("write3_mem_first", 64'(mem[32'h600]), 64'hFF);
      check("write3_mem_last", 64'(mem[32'h7FF]), 64'h00);

      // rd and wr together: read wins
      for (int i = 0; i < 512; i++) begin
         mem[i] = 8'(i * 7);
         rd_q.push_back(32'({9'(i), 8'(i * 7)}));
      end
      s0 = n_strobe; w0 = n_mwr;
      sector(1'b1, 1'b1, 32'd0);
      check_counts("rd_wr_both", s0, w0, 512, 0);

      // Save loop over lba 0x80..0x87
      s0 = n_strobe; w0 = n_mwr;
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < 512; i++) begin
            core_buf[i] = 8'(i) ^ 8'(s) ^ 8'hC3;
            wr_q.push_back(32'({24'(((32'h80 + s) << 9) + i), 8'(i) ^ 8'(s) ^ 8'hC3}));
         end
         sector(1'b0, 1'b1, 32'h80 + s);
      end
      check_counts("save_loop", s0, w0, 0, 8 * 512);

      // Stalled read of sector 0x80 (written above with s=0)
      stall_max = 7;
      for (int i = 0; i < 512; i++) rd_q.push_back(32'({9'(i), 8'(i) ^ 8'hC3}));
      s0 = n_strobe; w0 = n_mwr;
      sector(1'b1, 1'b0, 32'h80);
      check_counts("stall_read", s0, w0, 512, 0);

      // Stalled write of lba 0x10
      for (int i = 0; i < 512; i++) begin
         core_buf[i] = 8'(i + 8'h11);
         wr_q.push_back(32'({24'(32'h2000 + i), 8'(i + 8'h11)}));
      end
      s0 = n_strobe; w0 = n_mwr;
      sector(1'b0, 1'b1, 32'h10);
      check_counts("stall_write", s0, w0, 0, 512);

      // Reset in the middle of a read of lba=2
      stall_max = 1;
      for (int i = 0; i < 512; i++) begin
         mem[32'h400 + i] = 8'(i) ^ 8'h33;
         rd_q.push_back(32'({9'(i), 8'(i) ^ 8'h33}));
      end
      s0 = n_strobe;
      @(posedge clk_sys); #1;
      sd_lba = 32'd2; sd_rd = 1'b1;
      n_issued++;
      t = 0;
      while (!sd_ack && t < 100) begin @(posedge clk_sys); #1; t++; end
      check("rst_test_ack_rise", 64'(t < 100), 64'd1);
      sd_rd = 1'b0;
      t = 0;
      while ((n_strobe - s0) < 200 && t < 5000) begin @(posedge clk_sys); #1; t++; end
      check("rst_test_reach_200", 64'(t < 5000), 64'd1);
      reset = 1'b1;
      @(posedge clk_sys); #1;
      reset = 1'b0;
      late_ack = 1'b1;
      check("midrst_sd_ack", 64'(sd_ack), 64'd0);
      check("midrst_mem_req", 64'(mem_req), 64'd0);
      check("midrst_mem_we", 64'(mem_we), 64'd0);
      check("midrst_mem_addr", 64'(mem_addr), 64'd0);
      check("midrst_buff_wr", 64'(sd_buff_wr), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      rd_q.delete();
      s_at_rst = n_strobe;
      repeat (3) @(posedge clk_sys);
      #1;
      check("late_ack_ignored_busy", 64'(busy), 64'd0);
      check("late_ack_ignored_req", 64'(mem_req), 64'd0);
      check("late_ack_no_strobe", 64'(n_strobe - s_at_rst), 64'd0);

      // Fresh read lba=1 after the aborted transfer
      stall_max = 0;
      for (int i = 0; i < 512; i++) begin
         mem[32'h200 + i] = 8'(i + 8'h40);
         rd_q.push_back(32'({9'(i), 8'(i + 8'h40)}));
      end
      s0 = n_strobe; w0 = n_mwr;
      sector(1'b1, 1'b0, 32'd1);
      check_counts("read_after_rst", s0, w0, 512, 0);

      check("ack_pulse_count", 64'(n_ack_rise), 64'(n_issued));
      check("final_idle", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog");
   end

endmodule
